// File: rtl/uart_pkg.sv
// Shared definitions for the UART time-sync receive path: FSM states,
// field widths, range limits and the default frame header.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEC,
    ST_MIN,
    ST_HOUR,
    ST_DAY,
    ST_MON,
    ST_CHK,
    ST_DONE
  } tsync_state_t;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;
  localparam int unsigned DAY_W  = 5;
  localparam int unsigned MON_W  = 4;

  localparam logic [7:0] MAX_SEC  = 8'd59;
  localparam logic [7:0] MAX_MIN  = 8'd59;
  localparam logic [7:0] MAX_HOUR = 8'd23;
  localparam logic [7:0] MAX_DAY  = 8'd31;
  localparam logic [7:0] MAX_MON  = 8'd12;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // Day and month are 1-based; the remaining fields start at zero.
  function automatic logic fields_valid(input logic [7:0] sec, input logic [7:0] min,
                                        input logic [7:0] hour, input logic [7:0] day,
                                        input logic [7:0] mon);
    return (sec <= MAX_SEC) && (min <= MAX_MIN) && (hour <= MAX_HOUR) &&
           (day != 8'd0) && (day <= MAX_DAY) && (mon != 8'd0) && (mon <= MAX_MON);
  endfunction

endpackage

// File: rtl/uart_time_sync_rx_timeout.sv
// tsync_timeout: saturating inter-byte tick counter for the time-sync parser.
module tsync_timeout #(
  parameter int unsigned LIMIT = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic expired
);

  localparam logic [7:0] LIM    = 8'(LIMIT);
  localparam logic [7:0] LIM_M1 = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && tick && (count != LIM)) begin
      count <= count + 8'd1;
    end
  end

  // Flags the tick that reaches the limit so the parser aborts on that same edge.
  always_comb begin
    expired = enable && ((count == LIM) || (tick && (count == LIM_M1)));
  end

endmodule

// File: rtl/uart_time_sync_rx.sv
// UART time-set frame parser: HEADER, sec, min, hour, day, mon [, chk].
// Optional XOR checksum byte enabled by defining UART_TSYNC_CHECKSUM_EN.
module uart_time_sync_rx
  import uart_pkg::*;
#(
  parameter logic [7:0]  HEADER        = DEFAULT_HEADER,
  parameter int unsigned TIMEOUT_TICKS = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_err,
  output logic              load,
  output logic [SEC_W-1:0]  set_sec,
  output logic [MIN_W-1:0]  set_min,
  output logic [HOUR_W-1:0] set_hour,
  output logic [DAY_W-1:0]  set_day,
  output logic [MON_W-1:0]  set_mon,
  output logic              frame_err,
  output logic              busy
);

  tsync_state_t state;
  logic [7:0]   sh_sec, sh_min, sh_hour, sh_day, sh_mon;
`ifdef UART_TSYNC_CHECKSUM_EN
  logic [7:0]   xacc;
`endif

  logic tmo_clear, tmo_enable, tmo_expired;

  always_comb begin
    tmo_clear  = rx_valid || (state == ST_IDLE);
    tmo_enable = (state == ST_SEC) || (state == ST_MIN) || (state == ST_HOUR) ||
                 (state == ST_DAY) || (state == ST_MON) || (state == ST_CHK);
  end

  tsync_timeout #(.LIMIT(TIMEOUT_TICKS)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .tick    (tick),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      load      <= 1'b0;
      frame_err <= 1'b0;
      sh_sec    <= '0;
      sh_min    <= '0;
      sh_hour   <= '0;
      sh_day    <= '0;
      sh_mon    <= '0;
      set_sec   <= '0;
      set_min   <= '0;
      set_hour  <= '0;
      set_day   <= '0;
      set_mon   <= '0;
`ifdef UART_TSYNC_CHECKSUM_EN
      xacc      <= '0;
`endif
    end else begin
      load      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid && !rx_err && (rx_data == HEADER)) begin
            state <= ST_SEC;
            busy  <= 1'b1;
`ifdef UART_TSYNC_CHECKSUM_EN
            xacc  <= rx_data;
`endif
          end
        end
        ST_SEC, ST_MIN, ST_HOUR, ST_DAY, ST_MON, ST_CHK: begin
          // A byte in the same cycle as the timeout takes priority.
          if (rx_valid) begin
            if (rx_err) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
            end else begin
`ifdef UART_TSYNC_CHECKSUM_EN
              if (state != ST_CHK) xacc <= xacc ^ rx_data;
`endif
              case (state)
                ST_SEC:  begin sh_sec  <= rx_data; state <= ST_MIN;  end
                ST_MIN:  begin sh_min  <= rx_data; state <= ST_HOUR; end
                ST_HOUR: begin sh_hour <= rx_data; state <= ST_DAY;  end
                ST_DAY:  begin sh_day  <= rx_data; state <= ST_MON;  end
                ST_MON: begin
                  sh_mon <= rx_data;
`ifdef UART_TSYNC_CHECKSUM_EN
                  state  <= ST_CHK;
`else
                  state  <= ST_DONE;
`endif
                end
`ifdef UART_TSYNC_CHECKSUM_EN
                ST_CHK: begin
                  if (rx_data == xacc) begin
                    state <= ST_DONE;
                  end else begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    frame_err <= 1'b1;
                  end
                end
`endif
                default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end
              endcase
            end
          end else if (tmo_expired) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (fields_valid(sh_sec, sh_min, sh_hour, sh_day, sh_mon)) begin
            set_sec  <= sh_sec[SEC_W-1:0];
            set_min  <= sh_min[MIN_W-1:0];
            set_hour <= sh_hour[HOUR_W-1:0];
            set_day  <= sh_day[DAY_W-1:0];
            set_mon  <= sh_mon[MON_W-1:0];
            load     <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_time_sync_rx.sv
// Directed bench for uart_time_sync_rx: frame table plus timeout, DONE-drop
// and mid-frame reset sequences. Follows UART_TSYNC_CHECKSUM_EN like the RTL.
module tb_uart_time_sync_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic [7:0] rx_data = '0;
  logic       load, frame_err, busy;
  logic [5:0] set_sec, set_min;
  logic [4:0] set_hour, set_day;
  logic [3:0] set_mon;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned load_cnt = 0;
  int unsigned ferr_cnt = 0;

  always #5 clk = ~clk;

  uart_time_sync_rx #(.HEADER(8'hA5), .TIMEOUT_TICKS(40)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .load      (load),
    .set_sec   (set_sec),
    .set_min   (set_min),
    .set_hour  (set_hour),
    .set_day   (set_day),
    .set_mon   (set_mon),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (load) load_cnt <= load_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  typedef struct {
    logic [7:0] sec, min, hour, day, mon;
    int         err_idx;   // data byte carrying rx_err; 5 = none
    bit         chk_flip;
    bit         exp_load;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err, input logic tk);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_err   = err;
    tick     = tk;
    step();
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    tick     = 1'b0;
  endtask

  task automatic pulse_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic check_sets(input string tag, input logic [7:0] s, input logic [7:0] mi,
                            input logic [7:0] h, input logic [7:0] d, input logic [7:0] mo);
    check({tag, ".set_sec"},  32'(set_sec),  32'(s[5:0]));
    check({tag, ".set_min"},  32'(set_min),  32'(mi[5:0]));
    check({tag, ".set_hour"}, 32'(set_hour), 32'(h[4:0]));
    check({tag, ".set_day"},  32'(set_day),  32'(d[4:0]));
    check({tag, ".set_mon"},  32'(set_mon),  32'(mo[3:0]));
  endtask

  function automatic logic [7:0] xor5(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d,
                                      input logic [7:0] e);
    return 8'hA5 ^ a ^ b ^ c ^ d ^ e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  fb[6];
    logic [7:0]  ck;
    logic [7:0]  cur_sec, cur_min, cur_hour, cur_day, cur_mon;
    vec_t        v;
    bit          aborted;
    bit          err;
    int unsigned l0, f0;

    vecs[0]  = '{8'h1E, 8'h2D, 8'h11, 8'h0F, 8'h06, 5, 1'b0, 1'b1};
    vecs[1]  = '{8'h3C, 8'h00, 8'h00, 8'h01, 8'h01, 5, 1'b0, 1'b0};
`ifdef UART_TSYNC_CHECKSUM_EN
    vecs[2]  = '{8'h17, 8'h3B, 8'h00, 8'h01, 8'h01, 5, 1'b1, 1'b0};
`else
    vecs[2]  = '{8'h17, 8'h3B, 8'h00, 8'h01, 8'h01, 5, 1'b1, 1'b1};
`endif
    vecs[3]  = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 2, 1'b0, 1'b0};
    vecs[4]  = '{8'h3B, 8'h3B, 8'h17, 8'h1F, 8'h0C, 5, 1'b0, 1'b1};
    vecs[5]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 5, 1'b0, 1'b0};
    vecs[6]  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h0D, 5, 1'b0, 1'b0};
    vecs[7]  = '{8'h00, 8'h00, 8'h18, 8'h01, 8'h01, 5, 1'b0, 1'b0};
    vecs[8]  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 5, 1'b0, 1'b1};
    vecs[9]  = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h01, 5, 1'b0, 1'b0};
    vecs[10] = '{8'h00, 8'h3C, 8'h00, 8'h01, 8'h01, 5, 1'b0, 1'b0};
    vecs[11] = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h01, 5, 1'b0, 1'b0};

    cur_sec = '0; cur_min = '0; cur_hour = '0; cur_day = '0; cur_mon = '0;

    // Reset state
    step(); step();
    check("reset.load", 32'(load), 0);
    check("reset.frame_err", 32'(frame_err), 0);
    check("reset.busy", 32'(busy), 0);
    check_sets("reset", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    rst = 1'b1;
    step();

    // Junk in IDLE, and a header flagged with rx_err
    send_byte(8'h00, 1'b0, 1'b0);
    check("junk00.busy", 32'(busy), 0);
    send_byte(8'hFF, 1'b0, 1'b0);
    check("junkFF.busy", 32'(busy), 0);
    send_byte(8'hA5, 1'b1, 1'b0);
    check("errhdr.busy", 32'(busy), 0);
    step();
    check("junk.frame_err_cnt", 32'(ferr_cnt), 0);

    // Frame table
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      fb[0] = 8'hA5; fb[1] = v.sec; fb[2] = v.min; fb[3] = v.hour; fb[4] = v.day; fb[5] = v.mon;
      ck = xor5(v.sec, v.min, v.hour, v.day, v.mon);
      aborted = 1'b0;
      for (int j = 0; j < 6; j++) begin
        if (!aborted) begin
          err = (j >= 1) && ((j - 1) == v.err_idx);
          send_byte(fb[j], err, 1'b0);
          if (err) begin
            check($sformatf("v%0d.rxerr.frame_err", i), 32'(frame_err), 1);
            check($sformatf("v%0d.rxerr.busy", i), 32'(busy), 0);
            aborted = 1'b1;
          end
        end
      end
`ifdef UART_TSYNC_CHECKSUM_EN
      if (!aborted) begin
        send_byte(v.chk_flip ? (ck ^ 8'h01) : ck, 1'b0, 1'b0);
        if (v.chk_flip) begin
          check($sformatf("v%0d.chk.frame_err", i), 32'(frame_err), 1);
          check($sformatf("v%0d.chk.busy", i), 32'(busy), 0);
          aborted = 1'b1;
        end
      end
`endif
      if (!aborted) begin
        check($sformatf("v%0d.done.busy", i), 32'(busy), 1);
        check($sformatf("v%0d.done.load", i), 32'(load), 0);
        step();
        check($sformatf("v%0d.load", i), 32'(load), 32'(v.exp_load));
        check($sformatf("v%0d.frame_err", i), 32'(frame_err), 32'(!v.exp_load));
        check($sformatf("v%0d.busy", i), 32'(busy), 0);
        if (v.exp_load) begin
          cur_sec = v.sec; cur_min = v.min; cur_hour = v.hour; cur_day = v.day; cur_mon = v.mon;
        end
      end
      check_sets($sformatf("v%0d", i), cur_sec, cur_min, cur_hour, cur_day, cur_mon);
      step(); step();
    end

    // Timeout after header + 2 bytes
    f0 = ferr_cnt;
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h0A, 1'b0, 1'b0);
    send_byte(8'h14, 1'b0, 1'b0);
    pulse_ticks(39);
    check("tmo39.busy", 32'(busy), 1);
    check("tmo39.frame_err_cnt", 32'(ferr_cnt - f0), 0);
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("tmo40.frame_err", 32'(frame_err), 1);
    check("tmo40.busy", 32'(busy), 0);
    step(); step();

    // Byte on the 40th tick beats the timeout and restarts the count
    f0 = ferr_cnt;
    l0 = load_cnt;
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h0A, 1'b0, 1'b0);
    send_byte(8'h14, 1'b0, 1'b0);
    pulse_ticks(39);
    step();
    send_byte(8'h05, 1'b0, 1'b1);
    check("race.frame_err", 32'(frame_err), 0);
    check("race.busy", 32'(busy), 1);
    pulse_ticks(39);
    check("race39.busy", 32'(busy), 1);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
`ifdef UART_TSYNC_CHECKSUM_EN
    send_byte(xor5(8'h0A, 8'h14, 8'h05, 8'h02, 8'h03), 1'b0, 1'b0);
`endif
    step();
    check("race.load", 32'(load), 1);
    check("race.frame_err_cnt", 32'(ferr_cnt - f0), 0);
    check_sets("race", 8'd10, 8'd20, 8'd5, 8'd2, 8'd3);
    step(); step();

    // Header arriving during DONE is dropped; back-to-back bytes accepted
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
`ifdef UART_TSYNC_CHECKSUM_EN
    send_byte(xor5(8'h01, 8'h02, 8'h03, 8'h04, 8'h05), 1'b0, 1'b0);
`endif
    send_byte(8'hA5, 1'b0, 1'b0);
    check("drop.load", 32'(load), 1);
    check("drop.busy", 32'(busy), 0);
    step();
    check("drop.busy_after", 32'(busy), 0);
    check_sets("drop", 8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
    step(); step();

    // Reset pulse mid-frame after the MIN byte
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h0B, 1'b0, 1'b0);
    send_byte(8'h0C, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("rstmid.busy", 32'(busy), 0);
    check("rstmid.load", 32'(load), 0);
    check("rstmid.frame_err", 32'(frame_err), 0);
    check_sets("rstmid", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    l0 = load_cnt;
    f0 = ferr_cnt;
    step();
    rst = 1'b1;
    send_byte(8'h0D, 1'b0, 1'b0);
    send_byte(8'h0E, 1'b0, 1'b0);
    send_byte(8'h0F, 1'b0, 1'b0);
    send_byte(8'h10, 1'b0, 1'b0);
    step(); step(); step();
    check("rstmid.load_cnt", 32'(load_cnt - l0), 0);
    check("rstmid.frame_err_cnt", 32'(ferr_cnt - f0), 0);
    check("rstmid.busy_after", 32'(busy), 0);
    check_sets("rstmid_after", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
